// File: rtl/fma_operand_sequencer_pkg.sv
// Shared types for the FMA operand sequencer and the FMA core it drives.
// The FMA core uses the same core-state codes.
package fma_operand_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } seq_state_e;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// Small synchronous FIFO holding {activation, weight} operand pairs.
// Push is ignored when full and pop is ignored when empty.
module operand_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             push_ok;
  logic             pop_ok;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + (AddrW + 1)'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + (AddrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/fma_operand_sequencer.sv
// Feeds buffered operand pairs to an external FMA one term at a time and
// accumulates its results into a dot product; performs no arithmetic itself.
module fma_operand_sequencer
  import fma_operand_sequencer_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned LEN_BITS    = 8,
  parameter int unsigned FMA_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_BITS-1:0]  vec_len,
  input  logic [DATA_BITS-1:0] acc_init,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_act,
  input  logic [DATA_BITS-1:0] in_wgt,
  output logic [2:0]           fma_core_state,
  output logic                 fma_enable,
  output logic [DATA_BITS-1:0] fma_rs,
  output logic [DATA_BITS-1:0] fma_rt,
  output logic [DATA_BITS-1:0] fma_rq,
  input  logic [DATA_BITS-1:0] fma_out,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_BITS-1:0] res_data
);

  localparam int unsigned         LatW    = cnt_width(FMA_LATENCY);
  localparam logic [LatW-1:0]     LatLast = LatW'(FMA_LATENCY - 1);
  localparam logic [LEN_BITS-1:0] LenOne  = LEN_BITS'(1);

  seq_state_e             state_q;
  logic [LEN_BITS-1:0]    len_q;
  logic [LEN_BITS-1:0]    term_q;
  logic [LEN_BITS-1:0]    term_plus;
  logic [LatW-1:0]        lat_q;
  logic [DATA_BITS-1:0]   acc_q;
  logic [DATA_BITS-1:0]   rs_q;
  logic [DATA_BITS-1:0]   rt_q;
  logic [DATA_BITS-1:0]   rq_q;

  logic [2*DATA_BITS-1:0] head_pair;
  logic [DATA_BITS-1:0]   head_act;
  logic [DATA_BITS-1:0]   head_wgt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   issue;

  operand_fifo #(
    .Width (2 * DATA_BITS),
    .Depth (DEPTH)
  ) u_operand_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (in_valid),
    .push_data_i ({in_act, in_wgt}),
    .pop_i       (issue),
    .pop_data_o  (head_pair),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign {head_act, head_wgt} = head_pair;
  assign issue     = (state_q == StIssue) && !fifo_empty;
  assign term_plus = term_q + LenOne;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      term_q  <= '0;
      lat_q   <= '0;
      acc_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rq_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q   <= vec_len;
            acc_q   <= acc_init;
            term_q  <= '0;
            state_q <= (vec_len == '0) ? StDone : StIssue;
          end
        end
        StIssue: begin
          if (!fifo_empty) begin
            rs_q    <= head_act;
            rt_q    <= head_wgt;
            rq_q    <= acc_q;
            lat_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          // The FMA result is valid on the FMA_LATENCY-th edge after issue.
          if (lat_q == LatLast) begin
            acc_q   <= fma_out;
            term_q  <= term_plus;
            lat_q   <= '0;
            state_q <= (term_plus == len_q) ? StDone : StIssue;
          end else begin
            lat_q <= lat_q + LatW'(1);
          end
        end
        StDone: begin
          if (res_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Operand buses show the FIFO head only while issuing, else the last issue.
  assign fma_enable     = issue;
  assign fma_core_state = issue ? CORE_EXECUTE : CORE_IDLE;
  assign fma_rs         = issue ? head_act : rs_q;
  assign fma_rt         = issue ? head_wgt : rt_q;
  assign fma_rq         = issue ? acc_q : rq_q;

  assign in_ready  = !fifo_full;
  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StDone);
  assign res_data  = acc_q;

endmodule
